// File: rtl/branch_resolve_pkg.sv
// Shared widths, funct3 encodings and FSM states for the EX-stage branch resolution unit.
package branch_resolve_pkg;

  localparam int unsigned RegWidth = 32;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic {
    StIdle  = 1'b0,
    StFlush = 1'b1
  } br_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_taken_dec.sv
// Combinational B-type taken/illegal decode from funct3 and comparator flags.
module branch_taken_dec
  import branch_resolve_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3Beq:          taken_o = br_eq_i;
      F3Bne:          taken_o = ~br_eq_i;
      F3Blt, F3Bltu:  taken_o = br_lt_i;
      F3Bge, F3Bgeu:  taken_o = ~br_lt_i;
      default:        illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: taken decode, registered PC redirect and fixed-length IF/ID flush.
// Optional BRANCH_STATS_EN adds saturating branch/taken counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = RegWidth
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic            BrEq,
  input  logic            BrLT,
  input  logic [XLEN-1:0] target,
  output logic            BrUn,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            misalign_exc,
  output logic            illegal_br
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] CntInit = CntW'(FLUSH_CYCLES - 1);

  br_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misalign_q, misalign_d;
  logic            illegal_q, illegal_d;

  logic            dec_taken, dec_illegal;
  logic            taken, accept, aligned;
  logic [XLEN-1:0] eff_tgt;

  branch_taken_dec u_dec (
    .funct3_i  (funct3),
    .br_eq_i   (BrEq),
    .br_lt_i   (BrLT),
    .taken_o   (dec_taken),
    .illegal_o (dec_illegal)
  );

  assign BrUn    = funct3[1];
  assign taken   = (is_branch & dec_taken) | is_jal | is_jalr;
  assign eff_tgt = is_jalr ? {target[XLEN-1:1], 1'b0} : target;
  assign aligned = (eff_tgt[1:0] == 2'b00);
  assign accept  = ex_valid & ~ex_stall & (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      misalign_q       <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      misalign_q       <= misalign_d;
      illegal_q        <= illegal_d;
    end
  end

  // Pulses default low every cycle; stall only freezes the FSM and counter.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    misalign_d       = 1'b0;
    illegal_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          illegal_d = is_branch & dec_illegal;
          if (taken && aligned) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = eff_tgt;
            state_d          = StFlush;
            cnt_d            = CntInit;
          end else if (taken) begin
            misalign_d = 1'b1;
          end
        end
      end
      StFlush: begin
        if (!ex_stall) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    flush = (state_q == StFlush);
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign misalign_exc   = misalign_q;
  assign illegal_br     = illegal_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_taken_q, stat_taken_d;
  logic        legal_br;

  assign legal_br = accept & is_branch & ~dec_illegal;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_taken_d    = stat_taken_q;
    if (legal_br) begin
      stat_branches_d = sat_inc(stat_branches_q);
      if (dec_taken && aligned) begin
        stat_taken_d = sat_inc(stat_taken_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`endif

endmodule
